// File: rtl/issue_controller.sv
// issue_controller: fetch queue, issue register and stall/flush handling.
// Optional stall-bubble counter enabled by ISSUE_BUBBLE_COUNT_EN.
module issue_controller #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_instr,
    output logic        fetch_ready,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] issue_reg_output,
    output logic        issue_valid,
    output logic [31:0] decode_instr,
    output logic [31:0] bubble_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [31:0]      issue_reg;
    logic             iv;
    logic [31:0]      dec_reg;

    logic xfer;
    logic advance;
    logic load;
    logic pop;
    logic bypass;
    logic push;

    assign fetch_ready = !flush && (count < FULL);
    assign xfer        = fetch_valid && fetch_ready;
    assign advance     = iv && !stall;
    assign load        = !iv || advance;
    assign pop         = load && (count != '0);
    assign bypass      = load && (count == '0) && xfer;
    assign push        = xfer && !bypass;

    assign issue_reg_output = issue_reg;
    assign issue_valid      = iv;
    assign decode_instr     = dec_reg;

    // Queue storage: written at the tail on a push, no reset needed.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[tail] <= fetch_instr;
        end
    end

    // Pointers, occupancy, issue register and decode register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            iv        <= 1'b0;
            issue_reg <= 32'h0;
            dec_reg   <= 32'h0;
        end else begin
            dec_reg <= advance ? issue_reg : 32'h0;
            if (load) begin
                if (pop) begin
                    issue_reg <= mem[head];
                    iv        <= 1'b1;
                end else if (bypass) begin
                    issue_reg <= fetch_instr;
                    iv        <= 1'b1;
                end else begin
                    issue_reg <= 32'h0;
                    iv        <= 1'b0;
                end
            end
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef ISSUE_BUBBLE_COUNT_EN
    logic [31:0] bubble_q;

    // Saturating count of cycles a valid instruction was held by stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_q <= 32'h0;
        end else if (!flush && iv && stall && (bubble_q != 32'hFFFF_FFFF)) begin
            bubble_q <= bubble_q + 32'd1;
        end
    end

    assign bubble_count = bubble_q;
`else
    assign bubble_count = 32'h0;
`endif

endmodule
